// File: rtl/hist_pkg.sv
// Shared types and helpers for the histogram engine: controller state,
// bin-index width and the counter step rule (saturating or wrapping).
package hist_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        CLEAR = 2'd1,
        DRAIN = 2'd2
    } hist_state_e;

    // Width of a bin index; a two-bin histogram still needs one bit.
    function automatic int hist_bin_width(input int num_bins);
        return (num_bins <= 2) ? 1 : $clog2(num_bins);
    endfunction

    // Next value of a count_w-bit counter after one increment. Computed on a
    // 64-bit carrier so one function serves every counter width up to 64.
    function automatic logic [63:0] hist_count_next(input logic [63:0] cur,
                                                    input int          count_w,
                                                    input bit          saturate);
        logic [63:0] max_val;
        max_val = (count_w >= 64) ? '1 : ((64'd1 << count_w) - 64'd1);
        if (saturate && (cur == max_val)) begin
            return cur;
        end
        return (cur + 64'd1) & max_val;
    endfunction

endpackage

// File: rtl/hist_bin_counter.sv
// One histogram counter: synchronous clear has priority over increment,
// increment either sticks at all-ones or wraps to zero.
module hist_bin_counter
    import hist_pkg::*;
#(
    parameter int COUNT_W  = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_inc,
    input  logic               i_clr,
    output logic [COUNT_W-1:0] o_count
);

    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_next;

    assign w_next = COUNT_W'(hist_count_next(64'(r_count), COUNT_W, SATURATE));

    // Counter register: clear wins, otherwise step on increment.
    // NOTE: bins are individual reset flops rather than a RAM, so the async
    // reset and the one-cycle CLEAR can zero every bin at once; state is
    // written with <= so all counters update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/histogram_engine.sv
// Histogram engine: bins one sample per cycle by (sample >> BIN_SHIFT),
// counts out-of-range samples separately, clears on command and streams all
// bins over valid/ready/last with optional clear-on-read.
// Assumes NUM_BINS <= 2**DATA_W and BIN_W <= DATA_W.
module histogram_engine
    import hist_pkg::*;
#(
    parameter int  DATA_W    = 16,
    parameter int  NUM_BINS  = 32,
    parameter int  COUNT_W   = 8,
    parameter int  BIN_SHIFT = 0,
    parameter bit  SATURATE  = 1'b1,
    localparam int BIN_W     = hist_bin_width(NUM_BINS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic [DATA_W-1:0]  sample_data,
    input  logic               readout_start,
    input  logic               clear_start,
    input  logic               clear_on_read,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIN_W-1:0]   out_bin,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_last,
    output logic [COUNT_W-1:0] oor_count,
    output logic               busy
);

    localparam logic [DATA_W-1:0] LP_BIN_LIMIT = DATA_W'(NUM_BINS);
    localparam logic [BIN_W-1:0]  LP_LAST_BIN  = BIN_W'(NUM_BINS - 1);

    hist_state_e        r_state;
    hist_state_e        w_next_state;
    logic [BIN_W-1:0]   r_ptr;
    logic               r_cor;

    logic [DATA_W-1:0]  w_shifted;
    logic [BIN_W-1:0]   w_bin;
    logic               w_in_range;
    logic               w_accept;
    logic               w_sample_ready;
    logic               w_out_valid;
    logic               w_busy;
    logic               w_at_last;
    logic               w_beat_hs;
    logic               w_last_hs;
    logic               w_clear_all;
    logic               w_start_drain;
    logic [COUNT_W-1:0] w_counts [NUM_BINS];

    // Sample binning
    assign w_shifted  = sample_data >> BIN_SHIFT;
    assign w_bin      = w_shifted[BIN_W-1:0];
    assign w_in_range = (w_shifted < LP_BIN_LIMIT);
    assign w_accept   = sample_valid && w_sample_ready;

    // Readout and clear qualifiers
    assign w_at_last     = (r_ptr == LP_LAST_BIN);
    assign w_beat_hs     = w_out_valid && out_ready;
    assign w_last_hs     = w_beat_hs && w_at_last;
    assign w_clear_all   = (r_state == CLEAR);
    assign w_start_drain = (r_state == ACCUM) && (w_next_state == DRAIN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: clear beats readout; commands only count in ACCUM
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ACCUM: begin
                if (clear_start) begin
                    w_next_state = CLEAR;
                end else if (readout_start) begin
                    w_next_state = DRAIN;
                end
            end
            CLEAR:   w_next_state = ACCUM;
            DRAIN: begin
                if (w_last_hs) begin
                    w_next_state = ACCUM;
                end
            end
            default: w_next_state = ACCUM;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_sample_ready = 1'b0;
        w_out_valid    = 1'b0;
        w_busy         = 1'b1;
        case (r_state)
            ACCUM: begin
                w_sample_ready = 1'b1;
                w_busy         = 1'b0;
            end
            DRAIN:   w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Read pointer and clear-on-read flag, latched when a readout begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cor <= 1'b0;
        end else if (w_start_drain) begin
            r_ptr <= '0;
            r_cor <= clear_on_read;
        end else if (w_beat_hs) begin
            if (w_at_last) begin
                r_ptr <= '0;
                r_cor <= 1'b0;
            end else begin
                r_ptr <= r_ptr + BIN_W'(1);
            end
        end
    end

    // Per-bin counters; a bin clears when its beat is accepted with clear-on-read
    for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
        logic w_inc;
        logic w_clr;
        assign w_inc = w_accept && w_in_range && (w_bin == BIN_W'(g));
        assign w_clr = w_clear_all || (w_beat_hs && r_cor && (r_ptr == BIN_W'(g)));

        hist_bin_counter #(
            .COUNT_W  (COUNT_W),
            .SATURATE (SATURATE)
        ) u_bin (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_inc   (w_inc),
            .i_clr   (w_clr),
            .o_count (w_counts[g])
        );
    end

    // Out-of-range counter, cleared at the end of a clear-on-read stream
    hist_bin_counter #(
        .COUNT_W  (COUNT_W),
        .SATURATE (SATURATE)
    ) u_oor (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_accept && !w_in_range),
        .i_clr   (w_clear_all || (w_last_hs && r_cor)),
        .o_count (oor_count)
    );

    assign sample_ready = w_sample_ready;
    assign busy         = w_busy;
    assign out_valid    = w_out_valid;
    assign out_bin      = r_ptr;
    assign out_count    = w_out_valid ? w_counts[r_ptr] : '0;
    assign out_last     = w_out_valid && w_at_last;

endmodule

// File: tb/tb_histogram_engine.sv
// Directed bench for histogram_engine. Two instances share all inputs: u_sat
// (defaults, saturating) and u_wrap (SATURATE=0); their streams are captured
// side by side and compared with hand-computed bin counts.
module tb_histogram_engine;

    localparam int NB = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        readout_start = 1'b0;
    logic        clear_start = 1'b0;
    logic        clear_on_read = 1'b0;
    logic        out_ready = 1'b1;

    logic        sample_ready, out_valid, out_last, busy;
    logic [4:0]  out_bin;
    logic [7:0]  out_count, oor_count;
    logic        sample_ready_w, out_valid_w, out_last_w, busy_w;
    logic [4:0]  out_bin_w;
    logic [7:0]  out_count_w, oor_count_w;

    logic [7:0]  got   [NB];
    logic [7:0]  got_w [NB];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    histogram_engine u_sat (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
        .readout_start(readout_start), .clear_start(clear_start), .clear_on_read(clear_on_read),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_count(out_count), .out_last(out_last), .oor_count(oor_count), .busy(busy)
    );

    histogram_engine #(.SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(sample_valid), .sample_ready(sample_ready_w), .sample_data(sample_data),
        .readout_start(readout_start), .clear_start(clear_start), .clear_on_read(clear_on_read),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_bin(out_bin_w),
        .out_count(out_count_w), .out_last(out_last_w), .oor_count(oor_count_w), .busy(busy_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] value, input int n);
        sample_valid = 1'b1;
        sample_data  = value;
        repeat (n) step();
        sample_valid = 1'b0;
    endtask

    function automatic int sum_bins(input int skip);
        int s = 0;
        for (int i = 0; i < NB; i++) begin
            if (i != skip) s += int'(got[i]);
        end
        return s;
    endfunction

    // Start a readout and drain all beats into got/got_w. With stall set,
    // out_ready follows 1-0-0-1 and a sample of value 5 is offered throughout.
    task automatic do_readout(input bit cor, input bit stall, input bit with_sample,
                              input logic [15:0] sval, input string tag);
        int beats = 0, cyc = 0, n_stall = 0;
        int err_order = 0, err_last = 0, err_hold = 0, err_ready = 0, err_valid = 0;
        bit stalled;
        logic [4:0] h_bin;
        logic [7:0] h_cnt;
        logic       h_last;
        for (int i = 0; i < NB; i++) begin
            got[i]   = 8'hxx;
            got_w[i] = 8'hxx;
        end
        readout_start = 1'b1;
        clear_on_read = cor;
        sample_valid  = with_sample;
        sample_data   = sval;
        step();
        readout_start = 1'b0;
        clear_on_read = 1'b0;
        sample_valid  = stall;
        sample_data   = 16'd5;
        check({tag, "_first_valid"}, out_valid, 1);
        check({tag, "_first_bin"}, out_bin, 0);
        while (beats < NB && cyc < 400) begin
            stalled = 1'b0;
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (sample_ready !== 1'b0 || sample_ready_w !== 1'b0) err_ready++;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    got[out_bin]     = out_count;
                    got_w[out_bin_w] = out_count_w;
                    if (out_bin !== 5'(beats)) err_order++;
                    if (out_last !== (beats == NB - 1)) err_last++;
                    beats++;
                end else begin
                    stalled = 1'b1;
                    n_stall++;
                    h_bin  = out_bin;
                    h_cnt  = out_count;
                    h_last = out_last;
                end
            end else begin
                err_valid++;
            end
            step();
            cyc++;
            if (stalled && (out_bin !== h_bin || out_count !== h_cnt || out_last !== h_last))
                err_hold++;
        end
        sample_valid = 1'b0;
        out_ready    = 1'b1;
        check({tag, "_handshakes"}, beats, NB);
        check({tag, "_bin_order_errs"}, err_order, 0);
        check({tag, "_last_errs"}, err_last, 0);
        check({tag, "_ready_in_drain"}, err_ready, 0);
        check({tag, "_valid_gaps"}, err_valid, 0);
        if (stall) begin
            check({tag, "_stall_seen"}, n_stall > 0, 1);
            check({tag, "_hold_errs"}, err_hold, 0);
        end
        check({tag, "_valid_after"}, out_valid, 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int beats, cyc;

        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_out_count", out_count, 0);
        check("rst_busy", busy, 0);
        check("rst_oor", oor_count, 0);
        #5 rst_n = 1'b1;
        step();
        check("rel_sample_ready", sample_ready, 1);

        // Basic binning: three 15s, one out-of-range 40
        send(16'd15, 3);
        send(16'd40, 1);
        check("basic_oor", oor_count, 1);
        do_readout(1'b0, 1'b0, 1'b0, 16'd0, "basic");
        check("basic_bin15", got[15], 3);
        check("basic_others", sum_bins(15), 0);
        check("basic_wrap_bin15", got_w[15], 3);
        check("basic_oor_kept", oor_count, 1);

        // Explicit clear
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        check("clr_busy", busy, 1);
        check("clr_ready", sample_ready, 0);
        check("clr_valid", out_valid, 0);
        step();
        check("clr_busy_done", busy, 0);
        check("clr_oor", oor_count, 0);

        // 300 samples of 7: saturate at 255, wrap to 44; stalled readout
        send(16'd7, 300);
        do_readout(1'b0, 1'b1, 1'b0, 16'd0, "stall");
        check("sat_bin7", got[7], 255);
        check("wrap_bin7", got_w[7], 44);
        check("stall_others", sum_bins(7), 0);

        // Clear-on-read; value 5 offered during the stalled drain must be absent
        do_readout(1'b1, 1'b0, 1'b0, 16'd0, "cor_a");
        check("drain_sample_dropped", got[5], 0);
        check("cor_a_bin7", got[7], 255);

        // Clear-on-read with oor; second stream picks up a same-cycle sample
        send(16'd2, 5);
        send(16'd100, 2);
        check("cor_b_oor_pre", oor_count, 2);
        do_readout(1'b1, 1'b0, 1'b0, 16'd0, "cor_b");
        check("cor_b_bin2", got[2], 5);
        check("cor_b_others", sum_bins(2), 0);
        check("cor_b_oor_post", oor_count, 0);
        do_readout(1'b0, 1'b0, 1'b1, 16'd12, "cor_c");
        check("cor_c_bin12", got[12], 1);
        check("cor_c_others", sum_bins(12), 0);
        check("cor_c_oor", oor_count, 0);

        // Simultaneous readout_start and clear_start with a sample of 3
        send(16'd9, 2);
        sample_valid  = 1'b1;
        sample_data   = 16'd3;
        readout_start = 1'b1;
        clear_start   = 1'b1;
        step();
        sample_valid  = 1'b0;
        readout_start = 1'b0;
        clear_start   = 1'b0;
        check("both_busy", busy, 1);
        check("both_valid", out_valid, 0);
        check("both_ready", sample_ready, 0);
        step();
        check("both_busy_done", busy, 0);
        check("both_valid_done", out_valid, 0);
        check("both_ready_done", sample_ready, 1);
        do_readout(1'b0, 1'b0, 1'b0, 16'd0, "post_clr");
        check("post_clr_all", sum_bins(-1), 0);

        // Reset asserted while beat 10 is presented
        send(16'd4, 3);
        send(16'd50, 1);
        readout_start = 1'b1;
        step();
        readout_start = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats < 10 && cyc < 100) begin
            if (out_valid === 1'b1) beats++;
            step();
            cyc++;
        end
        check("mid_beats", beats, 10);
        check("mid_bin", out_bin, 10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_oor", oor_count, 0);
        #2 rst_n = 1'b1;
        step();
        check("mid_rel_ready", sample_ready, 1);
        do_readout(1'b0, 1'b0, 1'b0, 16'd0, "post_rst");
        check("post_rst_all", sum_bins(-1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/histogram_engine.md
Name: histogram_engine

Overview:
Parametrised successor to the fixed 16-bit histogramming block. It accepts one sample per cycle through a valid/ready handshake and bins it by `sample_data >> BIN_SHIFT`. Counters are per-bin, selectable saturating or wrapping, plus an out-of-range counter. On command, all bins stream out over a valid/ready/last interface, with optional clear-on-read. It sits between the sample source pins and the output/status mux in the top-level wrapper.

Parameters:
- DATA_W, 16, sample width in bits.
- NUM_BINS, 32, number of bins (≥2). BIN_W = clog2(NUM_BINS).
- COUNT_W, 8, width of each bin counter and of oor_count.
- BIN_SHIFT, 0, right-shift applied to the sample to form the bin index.
- SATURATE, 1, 1 = counters stick at 2^COUNT_W-1; 0 = counters wrap to 0.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  sample offered
- sample_ready  out  1  engine accepts samples (high only in ACCUM)
- sample_data  in  DATA_W  sample value
- readout_start  in  1  single-cycle request to stream all bins
- clear_start  in  1  single-cycle request to zero all counters
- clear_on_read  in  1  sampled at readout_start; zero each bin as it is read
- out_valid  out  1  readout beat valid
- out_ready  in  1  downstream accepts beat
- out_bin  out  BIN_W  index of current beat
- out_count  out  COUNT_W  count of current beat
- out_last  out  1  current beat is bin NUM_BINS-1
- oor_count  out  COUNT_W  out-of-range sample counter, live
- busy  out  1  high when not in ACCUM

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All bin counters and oor_count are 0.
  - State is ACCUM; sample_ready=1 after release.
  - out_valid=0, out_last=0, out_bin=0, out_count=0, busy=0.
  - The read pointer and the latched clear_on_read flag are 0.
  - A reset mid-readout aborts the stream immediately; there is no partial completion.
- States:
  - ACCUM → DRAIN on readout_start.
  - ACCUM → CLEAR on clear_start.
  - CLEAR → ACCUM after 1 cycle.
  - DRAIN → ACCUM on the handshake of the last beat.
- ACCUM:
  - A sample is accepted when sample_valid && sample_ready.
  - idx = sample_data >> BIN_SHIFT. If idx < NUM_BINS, counter[idx] increments; otherwise oor_count increments.
  - The new count is visible the next cycle. Back-to-back samples to the same bin each count, with no lost increments.
- Arithmetic:
  - SATURATE=1: a counter at all-ones holds its value.
  - SATURATE=0: a counter wraps to 0.
  - oor_count follows the same rule.
- Same-cycle start and sample:
  - A sample accepted in the same cycle as readout_start or clear_start is counted, then the transition occurs.
  - For clear_start, the clear takes effect one cycle later and therefore includes that sample.
- Simultaneous readout_start and clear_start in ACCUM: clear wins and readout_start is dropped.
- Start commands outside ACCUM are ignored.
- sample_ready = (state == ACCUM), registered. It is 0 in CLEAR and DRAIN; samples offered then are not accepted and not counted.
- DRAIN:
  - First beat: out_valid=1 the cycle after readout_start, with out_bin=0 and out_count=counter[0].
  - out_bin, out_count and out_last hold stable while out_valid && !out_ready.
  - On handshake: if the latched clear_on_read is set, counter[ptr] becomes 0; ptr increments and the next beat presents the following cycle, giving a maximum of 1 beat per cycle.
  - out_last=1 exactly on the beat with out_bin=NUM_BINS-1.
  - After the last handshake: out_valid=0 and state is ACCUM. oor_count is also zeroed at that point if clear_on_read was latched.
- CLEAR: all counters and oor_count are zeroed in one cycle.
- busy = (state != ACCUM).

Decomposition:
- Package hist_pkg:
  - state enum {ACCUM, CLEAR, DRAIN}.
  - clog2-based BIN_W helper.
  - Saturating/wrapping increment function parametrised by COUNT_W.
- One natural sub-module: hist_bin_counter, a single counter with inc, clr, saturate and the async reset. It is instantiated NUM_BINS times via generate, plus once for oor_count.

Test Plan:
- Reset with defaults, then 3 samples of value 15 and 1 of value 40 → counter[15]=3, oor_count=1, all other bins 0; readout streams 32 beats, beat 15 count=3, out_last only on bin 31.
- SATURATE=1, 300 samples of value 7 → readout bin 7 = 255. SATURATE=0, same stimulus → bin 7 = 44.
- Readout with out_ready toggled 1-0-0-1 → each beat held stable while stalled; exactly 32 handshakes; sample_ready=0 throughout; samples offered during DRAIN are not counted.
- clear_on_read=1 readout after 5 samples of value 2, then a second readout → first stream shows bin2=5, second stream shows all zeros and oor_count=0.
- readout_start and clear_start together, with sample value 3 accepted the same cycle → state goes to CLEAR; one cycle later all counters are 0; no out_valid ever asserted.
- rst_n pulsed low at beat 10 of a readout → out_valid falls immediately, all counters 0, sample_ready=1 after release.
